gp_instruction_encoder: RTL and testbench

Packs field-level instruction tuples (opcode, rd, rs1, rs2, func, imm) into 16-bit MAK-8/vector words and streams them into GP-Core instruction memory. Serves the debug/boot loader path and is the inverse of the GP-Core decode stage. Accepts tuples over a valid/ready handshake, range-checks immediates, buffers encoded words in a small FIFO, and writes them to sequential IMEM addresses under memory backpressure.

---
 rtl/gp_isa_pkg.sv | 89 ++++++++
 rtl/gp_enc_fifo.sv | 61 ++++++
 rtl/gp_instruction_encoder.sv | 159 +++++++++++++++
 tb/tb_gp_instruction_encoder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gp_isa_pkg.sv
// Shared GP-Core ISA definitions for the instruction encoder: opcodes, field positions,
// immediate limits, FSM states and the tuple-to-word encode function.
package gp_isa_pkg;

    localparam logic [3:0]  OP_RTYPE = 4'h0;
    localparam logic [3:0]  OP_ADDI  = 4'h1;
    localparam logic [3:0]  OP_LDB   = 4'h7;
    localparam logic [3:0]  OP_STB   = 4'h8;
    localparam logic [3:0]  OP_BR    = 4'h9;
    localparam logic [3:0]  OP_VEC   = 4'hB;
    localparam logic [15:0] NOP_WORD = 16'hF000;

    localparam int OPC_LSB  = 12;
    localparam int RD_LSB   = 9;
    localparam int RS1_LSB  = 6;
    localparam int RS2_LSB  = 3;
    localparam int FUNC_LSB = 0;
    localparam int IMM_LSB  = 0;
    localparam int OPC_W    = 4;
    localparam int REG_W    = 3;
    localparam int IMM6_W   = 6;
    localparam int IMM9_W   = 9;

    localparam logic signed [15:0] IMM6_MIN = -16'sd32;
    localparam logic signed [15:0] IMM6_MAX = 16'sd31;
    localparam logic signed [15:0] IMM9_MIN = -16'sd256;
    localparam logic signed [15:0] IMM9_MAX = 16'sd255;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } enc_state_t;

    typedef struct packed {
        logic [15:0] word;
        logic        illegal;
        logic        range_err;
    } enc_result_t;

    // Rejected tuples still produce a NOP so the IMEM address sequence stays aligned.
    function automatic enc_result_t encode_tuple(
        input logic [3:0]         opcode,
        input logic [2:0]         rd,
        input logic [2:0]         rs1,
        input logic [2:0]         rs2,
        input logic [2:0]         func,
        input logic signed [15:0] imm
    );
        enc_result_t res;
        res.word      = '0;
        res.illegal   = 1'b0;
        res.range_err = 1'b0;
        res.word[OPC_LSB +: OPC_W] = opcode;
        case (opcode)
            OP_RTYPE, OP_VEC: begin
                res.word[RD_LSB   +: REG_W] = rd;
                res.word[RS1_LSB  +: REG_W] = rs1;
                res.word[RS2_LSB  +: REG_W] = rs2;
                res.word[FUNC_LSB +: REG_W] = func;
            end
            OP_ADDI, OP_LDB, OP_STB: begin
                if (imm >= IMM6_MIN && imm <= IMM6_MAX) begin
                    res.word[RD_LSB  +: REG_W]  = rd;
                    res.word[RS1_LSB +: REG_W]  = rs1;
                    res.word[IMM_LSB +: IMM6_W] = imm[IMM6_W-1:0];
                end else begin
                    res.word      = NOP_WORD;
                    res.range_err = 1'b1;
                end
            end
            OP_BR: begin
                if (imm >= IMM9_MIN && imm <= IMM9_MAX) begin
                    res.word[RD_LSB  +: REG_W]  = rd;
                    res.word[IMM_LSB +: IMM9_W] = imm[IMM9_W-1:0];
                end else begin
                    res.word      = NOP_WORD;
                    res.range_err = 1'b1;
                end
            end
            default: begin
                res.word    = NOP_WORD;
                res.illegal = 1'b1;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/gp_enc_fifo.sv
// Synchronous FIFO buffering encoded words between tuple acceptance and IMEM writes.
// DEPTH must be a power of two; push when full and pop when empty are ignored.
module gp_enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_DEPTH);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: count_d is assigned on every path before the case, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers define validity and consumers gate the head on !empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/gp_instruction_encoder.sv
// Encodes field tuples into 16-bit GP-Core words and streams them into sequential IMEM addresses.
// Optional GP_ENC_CHECKSUM_EN adds a running XOR checksum of completed IMEM words.
module gp_instruction_encoder
    import gp_isa_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_rs1,
    input  logic [2:0]        in_rs2,
    input  logic [2:0]        in_func,
    input  logic [15:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_range,
    output logic [ADDR_W:0]   words_written
`ifdef GP_ENC_CHECKSUM_EN
   ,output logic [15:0]       checksum
`endif
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    enc_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   num_q, num_d;
    logic [ADDR_W:0]   acc_q, acc_d;
    logic [ADDR_W:0]   wr_q, wr_d;
    logic              err_ill_q, err_ill_d;
    logic              err_rng_q, err_rng_d;
`ifdef GP_ENC_CHECKSUM_EN
    logic [15:0]       csum_q, csum_d;
`endif

    enc_result_t enc;
    logic        fifo_full, fifo_empty;
    logic [15:0] fifo_head;
    logic        push, pop;

    assign enc = encode_tuple(in_opcode, in_rd, in_rs1, in_rs2, in_func, in_imm);

    assign in_ready      = (state_q == RUN) && !fifo_full && (acc_q < num_q);
    assign imem_we       = (state_q == RUN) && !fifo_empty;
    assign imem_wdata    = imem_we ? fifo_head : '0;
    assign imem_addr     = addr_q;
    assign push          = in_valid && in_ready;
    assign pop           = imem_we && imem_ready;
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign err_illegal   = err_ill_q;
    assign err_range     = err_rng_q;
    assign words_written = wr_q;
`ifdef GP_ENC_CHECKSUM_EN
    assign checksum      = csum_q;
`endif

    gp_enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (enc.word),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        num_d     = num_q;
        acc_d     = acc_q;
        wr_d      = wr_q;
        err_ill_d = err_ill_q;
        err_rng_d = err_rng_q;
`ifdef GP_ENC_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d    = base_addr;
                    num_d     = num_words;
                    acc_d     = '0;
                    wr_d      = '0;
                    err_ill_d = 1'b0;
                    err_rng_d = 1'b0;
`ifdef GP_ENC_CHECKSUM_EN
                    csum_d    = '0;
`endif
                    state_d   = (num_words != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (push) begin
                    acc_d     = acc_q + CNT_ONE;
                    err_ill_d = err_ill_q | enc.illegal;
                    err_rng_d = err_rng_q | enc.range_err;
                end
                // Address wraps naturally at 2^ADDR_W.
                if (pop) begin
                    addr_d = addr_q + ADDR_ONE;
                    wr_d   = wr_q + CNT_ONE;
`ifdef GP_ENC_CHECKSUM_EN
                    csum_d = csum_q ^ fifo_head;
`endif
                    if (wr_d == num_q) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            num_q     <= '0;
            acc_q     <= '0;
            wr_q      <= '0;
            err_ill_q <= 1'b0;
            err_rng_q <= 1'b0;
`ifdef GP_ENC_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            num_q     <= num_d;
            acc_q     <= acc_d;
            wr_q      <= wr_d;
            err_ill_q <= err_ill_d;
            err_rng_q <= err_rng_d;
`ifdef GP_ENC_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_gp_instruction_encoder.sv
// Scoreboard bench for gp_instruction_encoder: expected IMEM writes are queued at tuple
// acceptance and compared in order as the DUT completes writes.
module tb_gp_instruction_encoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] num_words;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [2:0]  in_rd, in_rs1, in_rs2, in_func;
    logic [15:0] in_imm;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        imem_ready;
    logic        busy, done, err_illegal, err_range;
    logic [10:0] words_written;
`ifdef GP_ENC_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    gp_instruction_encoder #(
        .ADDR_W     (10),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .num_words     (num_words),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_rd         (in_rd),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_func       (in_func),
        .in_imm        (in_imm),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .imem_ready    (imem_ready),
        .busy          (busy),
        .done          (done),
        .err_illegal   (err_illegal),
        .err_range     (err_range),
        .words_written (words_written)
`ifdef GP_ENC_CHECKSUM_EN
       ,.checksum      (checksum)
`endif
    );

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rd, rs1, rs2, func;
        logic [15:0] imm;
        logic [15:0] exp;
    } tuple_t;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] data;
    } exp_t;

    tuple_t tup_q[$];
    exp_t   exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int acc_cnt  = 0;
    int first_acc_cyc = -1;
    int first_we_cyc  = -1;
    logic [9:0]  addr_model;
    logic        prev_stall = 1'b0;
    logic [9:0]  prev_addr;
    logic [15:0] prev_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] rword(input int op, input int rd, input int rs1,
                                          input int rs2, input int func);
        return {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 3'(func)};
    endfunction

    task automatic add_tuple(input int op, input int rd, input int rs1, input int rs2,
                             input int func, input int imm, input int exp);
        tuple_t t;
        t.op = 4'(op); t.rd = 3'(rd); t.rs1 = 3'(rs1); t.rs2 = 3'(rs2);
        t.func = 3'(func); t.imm = 16'(imm); t.exp = 16'(exp);
        tup_q.push_back(t);
    endtask

    // Monitor: completed writes, stall stability and done pulses, sampled mid-cycle.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_we",   32'(imem_we), 1);
                check("stall_addr", 32'(imem_addr), 32'(prev_addr));
                check("stall_data", 32'(imem_wdata), 32'(prev_data));
            end
            if (done) done_cnt++;
            if (imem_we && imem_ready) begin
                if (first_we_cyc < 0) first_we_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(imem_we), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(imem_addr), 32'(e.addr));
                    check("wr_data", 32'(imem_wdata), 32'(e.data));
                end
            end
            prev_stall = imem_we && !imem_ready;
            prev_addr  = imem_addr;
            prev_data  = imem_wdata;
        end
    end

    task automatic start_job(input int base, input int n);
        @(negedge clk);
        base_addr = 10'(base);
        num_words = 11'(n);
        start     = 1'b1;
        addr_model    = 10'(base);
        done_cnt      = 0;
        acc_cnt       = 0;
        first_acc_cyc = -1;
        first_we_cyc  = -1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_tuples();
        tuple_t t;
        int     waitc;
        while (tup_q.size() != 0) begin
            t = tup_q.pop_front();
            in_valid = 1'b1;
            in_opcode = t.op; in_rd = t.rd; in_rs1 = t.rs1;
            in_rs2 = t.rs2; in_func = t.func; in_imm = t.imm;
            #1;
            waitc = 0;
            while (!in_ready && waitc < 100) begin
                @(negedge clk);
                #1;
                waitc++;
            end
            if (!in_ready) begin
                check("in_ready_timeout", 32'(in_ready), 1);
                in_valid = 1'b0;
                tup_q.delete();
                return;
            end
            exp_q.push_back('{addr: addr_model, data: t.exp});
            addr_model = addr_model + 10'd1;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            acc_cnt++;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int c;
        #1;
        c = 0;
        while (!done && c < 300) begin
            @(negedge clk);
            #1;
            c++;
        end
        check("done_seen", 32'(done), 1);
    endtask

    task automatic end_checks(input int n, input int e_ill, input int e_rng);
        @(negedge clk);
        #3;
        check("done_once",     done_cnt, 1);
        check("done_cleared",  32'(done), 0);
        check("busy_idle",     32'(busy), 0);
        check("words_written", 32'(words_written), n);
        check("err_illegal",   32'(err_illegal), e_ill);
        check("err_range",     32'(err_range), e_rng);
        check("sb_drained",    exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
        in_valid = 1'b0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_func = '0; in_imm = '0; imem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready), 0);
        check("rst_imem_we",   32'(imem_we), 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_wdata",     32'(imem_wdata), 0);
        check("rst_busy",      32'(busy), 0);
        check("rst_done",      32'(done), 0);
        check("rst_err",       32'({err_illegal, err_range}), 0);
        check("rst_words",     32'(words_written), 0);
        rst = 1'b0;

        // Basic encodes and first-write latency
        add_tuple(0, 1, 2, 3, 0, 0, 16'h0298);
        add_tuple(1, 1, 2, 0, 0, -1, 16'h12BF);
        add_tuple(9, 0, 0, 0, 0, -256, 16'h9100);
        start_job(16'h010, 3);
        check("t1_busy", 32'(busy), 1);
        drive_tuples();
        wait_done();
        end_checks(3, 0, 0);
        check("t1_latency", first_we_cyc - first_acc_cyc, 1);

        // Range error and illegal opcode both become NOPs; flags sticky
        add_tuple(1, 2, 3, 0, 0, 32, 16'hF000);
        add_tuple(3, 1, 1, 1, 1, 0, 16'hF000);
        start_job(16'h040, 2);
        drive_tuples();
        wait_done();
        end_checks(2, 1, 1);
        repeat (3) @(negedge clk);
        #1;
        check("t2_sticky", 32'({err_illegal, err_range}), 32'h3);

        // Backpressure: FIFO fills at 4 while IMEM is stalled
        imem_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            add_tuple((i % 2 == 1) ? 11 : 0, i, 7 - i, i + 1, i, 0,
                      32'(rword((i % 2 == 1) ? 11 : 0, i, 7 - i, i + 1, i)));
        start_job(16'h020, 8);
        check("t3_err_cleared", 32'({err_illegal, err_range}), 0);
        fork
            drive_tuples();
            begin
                repeat (10) @(negedge clk);
                #1;
                check("t3_acc_at_full", acc_cnt, 4);
                check("t3_in_ready_full", 32'(in_ready), 0);
                imem_ready = 1'b1;
            end
        join
        wait_done();
        end_checks(8, 0, 0);

        // Address wrap and immediate boundary values
        add_tuple(7, 1, 2, 0, 0, 31, 16'h729F);
        add_tuple(8, 3, 4, 0, 0, -32, 16'h8720);
        add_tuple(9, 5, 0, 0, 0, 255, 16'h9AFF);
        add_tuple(11, 7, 6, 5, 4, 0, 16'hBFAC);
        start_job(16'h3FE, 4);
        drive_tuples();
        wait_done();
        end_checks(4, 0, 0);

        // Zero-length job
        start_job(16'h055, 0);
        #1;
        check("t5_done", 32'(done), 1);
        check("t5_busy", 32'(busy), 0);
        check("t5_we",   32'(imem_we), 0);
        @(negedge clk);
        #1;
        check("t5_done_pulse", 32'(done), 0);
        check("t5_busy2",      32'(busy), 0);
        check("t5_words",      32'(words_written), 0);

        // Reset mid-job with words buffered, then a clean re-run
        imem_ready = 1'b0;
        add_tuple(0, 1, 1, 1, 1, 0, 32'(rword(0, 1, 1, 1, 1)));
        add_tuple(0, 2, 2, 2, 2, 0, 32'(rword(0, 2, 2, 2, 2)));
        start_job(16'h200, 4);
        drive_tuples();
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        #1;
        check("t6_we",       32'(imem_we), 0);
        check("t6_busy",     32'(busy), 0);
        check("t6_words",    32'(words_written), 0);
        check("t6_addr",     32'(imem_addr), 0);
        check("t6_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        imem_ready = 1'b1;
        repeat (4) @(negedge clk);
        add_tuple(11, 3, 2, 1, 0, 0, 32'(rword(11, 3, 2, 1, 0)));
        add_tuple(0, 4, 5, 6, 7, 0, 32'(rword(0, 4, 5, 6, 7)));
        start_job(16'h100, 2);
        drive_tuples();
        wait_done();
        end_checks(2, 0, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
